// File: rtl/sensor_scan_framer.sv
// sensor_scan_framer: scans mux channels, averages ADC samples, packs checksummed frames into a byte FIFO
module sensor_scan_framer #(
  parameter int NUM_CH = 24,
  parameter int SETTLE_CYC = 500,
  parameter int AVG_LOG2 = 2,
  parameter logic [7:0] HDR0 = 8'hAA,
  parameter logic [7:0] HDR1 = 8'h55,
  parameter int FIFO_DEPTH = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [11:0] adc_data,
  input  logic        adc_valid,
  output logic [5:0]  addr,
  output logic        busy,
  output logic [7:0]  tx_data,
  output logic        tx_empty,
  input  logic        tx_rd_en
);
  localparam int FW = NUM_CH + 4;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(SETTLE_CYC + 4);
  localparam int NS = 1 << AVG_LOG2;
  typedef enum logic [2:0] {IDLE, WAIT_SPACE, HDR, SETTLE, DISCARD, ACCUM, STORE, CHK} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [AVG_LOG2:0] n;
  logic [11+AVG_LOG2:0] acc;
  logic [7:0] frame_cnt, chk, wr_data, avg_byte;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] count;
  logic wr, rd;
  assign avg_byte = acc[AVG_LOG2+4 +: 8];
  assign wr = state inside {HDR, STORE, CHK};
  assign rd = tx_rd_en && count != '0;
  assign tx_empty = count == '0;
  assign tx_data = tx_empty ? 8'h00 : mem[rp];
  assign busy = state inside {HDR, SETTLE, DISCARD, ACCUM, STORE, CHK};
  assign wr_data = state == HDR ? (cnt == CW'(0) ? HDR0 : cnt == CW'(1) ? HDR1 : frame_cnt) :
                   state == STORE ? avg_byte : chk;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:       nxt = run ? WAIT_SPACE : IDLE;
      WAIT_SPACE: nxt = count <= (AW+1)'(FIFO_DEPTH - FW) ? HDR : WAIT_SPACE;
      HDR:        nxt = cnt == CW'(2) ? SETTLE : HDR;
      SETTLE:     nxt = cnt == CW'(SETTLE_CYC - 1) ? DISCARD : SETTLE;
      DISCARD:    nxt = adc_valid ? ACCUM : DISCARD;
      ACCUM:      nxt = adc_valid && n == (AVG_LOG2+1)'(NS - 1) ? STORE : ACCUM;
      STORE:      nxt = addr == 6'(NUM_CH - 1) ? CHK : SETTLE;
      CHK:        nxt = run ? WAIT_SPACE : IDLE;
      default:    nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      n <= '0;
      acc <= '0;
      frame_cnt <= '0;
      chk <= '0;
      addr <= '0;
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      state <= nxt;
      cnt <= nxt == state ? cnt + 1'b1 : '0;
      if (nxt == SETTLE && state != SETTLE) addr <= state == STORE ? addr + 6'd1 : 6'd0;
      if (state == DISCARD) begin
        acc <= '0;
        n <= '0;
      end else if (state == ACCUM && adc_valid) begin
        acc <= acc + (12+AVG_LOG2)'(adc_data);
        n <= n + 1'b1;
      end
      if (state == HDR) chk <= frame_cnt;
      else if (state == STORE) chk <= chk + avg_byte;
      if (state == CHK) frame_cnt <= frame_cnt + 8'd1;
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
      if (wr != rd) count <= wr ? count + 1'b1 : count - 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (wr && !reset) mem[wp] <= wr_data;
  end
endmodule

// File: tb/tb_sensor_scan_framer.sv
// tb_sensor_scan_framer: directed frame-level checks of the scan framer with a short settle time
module tb_sensor_scan_framer;
  localparam int SC = 4;
  localparam int FL = 28;
  logic clk = 0, reset, run, tx_rd_en, tx_empty, busy;
  logic [11:0] adc_data, gen_d, man_d;
  logic adc_valid, gen_v, man_v, gen_on;
  logic [5:0] addr;
  logic [7:0] tx_data;
  int gen_per = 1, gcnt = 0, n_chk = 0, n_pass = 0;
  assign adc_valid = gen_v | man_v;
  assign adc_data = gen_on ? gen_d : man_d;
  sensor_scan_framer #(.SETTLE_CYC(SC)) dut (
    .clk(clk), .reset(reset), .run(run), .adc_data(adc_data), .adc_valid(adc_valid),
    .addr(addr), .busy(busy), .tx_data(tx_data), .tx_empty(tx_empty), .tx_rd_en(tx_rd_en)
  );
  initial forever #10 clk = ~clk;
  initial begin
    gen_v = 0;
    forever begin
      @(negedge clk);
      if (!gen_on) begin
        gen_v = 0;
        gcnt = 0;
      end else if (gcnt + 1 >= gen_per) begin
        gen_v = 1;
        gcnt = 0;
      end else begin
        gen_v = 0;
        gcnt++;
      end
    end
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
  endtask
  function automatic logic [7:0] fexp(input logic [7:0] cnt, input logic [7:0] b0, input logic [7:0] b, input int i);
    return i == 0 ? 8'hAA : i == 1 ? 8'h55 : i == 2 ? cnt : i == 3 ? b0 :
           i == FL - 1 ? 8'(cnt + b0 + 23 * b) : b;
  endfunction
  task automatic pop(output logic [7:0] v);
    int t = 0;
    while (tx_empty && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("pop_wait", 32'(tx_empty), 32'(0));
    v = tx_data;
    tx_rd_en = 1;
    @(negedge clk);
    tx_rd_en = 0;
  endtask
  task automatic read_frame(input string tag, input logic [7:0] cnt, input logic [7:0] b0, input logic [7:0] b);
    logic [7:0] v;
    for (int i = 0; i < FL; i++) begin
      pop(v);
      check($sformatf("%s[%0d]", tag, i), 32'(v), 32'(fexp(cnt, b0, b, i)));
    end
  endtask
  task automatic wait_busy(input logic v, input int lim, input string tag);
    int t = 0;
    while (busy !== v && t < lim) begin
      @(negedge clk);
      t++;
    end
    check(tag, 32'(busy), 32'(v));
  endtask
  task automatic wait_addr(input logic [5:0] a, input int lim, input string tag);
    int t = 0;
    while (addr !== a && t < lim) begin
      @(negedge clk);
      t++;
    end
    check(tag, 32'(addr), 32'(a));
  endtask
  task automatic do_reset();
    reset = 1;
    run = 0;
    repeat (3) @(negedge clk);
    reset = 0;
  endtask
  task automatic send(input logic [11:0] d);
    man_d = d;
    man_v = 1;
    @(negedge clk);
    man_v = 0;
    @(negedge clk);
  endtask
  initial begin
    logic [7:0] v;
    tx_rd_en = 0;
    man_v = 0;
    man_d = 0;
    gen_on = 0;
    gen_d = 0;
    do_reset();
    check("rst_addr", 32'(addr), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_empty", 32'(tx_empty), 1);
    check("rst_data", 32'(tx_data), 0);
    // one frame from a short run pulse, constant samples
    gen_per = 32;
    gen_d = 12'hABC;
    gen_on = 1;
    run = 1;
    wait_busy(1, 10, "t1_busy_rise");
    check("t1_empty_hdr", 32'(tx_empty), 1);
    @(negedge clk);
    check("t1_empty_fall", 32'(tx_empty), 0);
    check("t1_head", 32'(tx_data), 32'h AA);
    repeat (45) @(negedge clk);
    run = 0;
    read_frame("t1", 8'h00, 8'hAB, 8'hAB);
    repeat (300) @(negedge clk);
    check("t1_idle_empty", 32'(tx_empty), 1);
    check("t1_idle_busy", 32'(busy), 0);
    // channel 0 averaging with a sample on the last settle cycle
    gen_on = 0;
    run = 1;
    wait_busy(1, 10, "t2_busy_rise");
    run = 0;
    repeat (SC + 2) @(negedge clk);
    send(12'hFFF);
    send(12'h0FF);
    send(12'h100);
    send(12'h101);
    check("t2_addr_a", 32'(addr), 0);
    send(12'h102);
    check("t2_addr_b", 32'(addr), 0);
    man_d = 12'h103;
    man_v = 1;
    @(negedge clk);
    man_v = 0;
    check("t2_addr_store", 32'(addr), 0);
    @(negedge clk);
    check("t2_addr_next", 32'(addr), 1);
    gen_per = 4;
    gen_d = 12'h000;
    gen_on = 1;
    read_frame("t2", 8'h01, 8'h10, 8'h00);
    // back-pressure: two frames fill the FIFO, third waits for space
    do_reset();
    gen_per = 1;
    gen_d = 12'h5A0;
    run = 1;
    wait_busy(1, 20, "t3_f0_start");
    wait_busy(0, 1000, "t3_f0_end");
    wait_busy(1, 20, "t3_f1_start");
    wait_busy(0, 1000, "t3_f1_end");
    repeat (50) @(negedge clk);
    check("t3_stall", 32'(busy), 0);
    for (int k = 0; k < 19; k++) begin
      pop(v);
      check($sformatf("t3[%0d]", k), 32'(v), 32'(fexp(8'(k / FL), 8'h5A, 8'h5A, k % FL)));
    end
    repeat (5) @(negedge clk);
    check("t3_stall19", 32'(busy), 0);
    pop(v);
    check("t3[19]", 32'(v), 32'(fexp(8'h00, 8'h5A, 8'h5A, 19)));
    wait_busy(1, 10, "t3_f2_start");
    run = 0;
    for (int k = 20; k < 3 * FL; k++) begin
      pop(v);
      check($sformatf("t3[%0d]", k), 32'(v), 32'(fexp(8'(k / FL), 8'h5A, 8'h5A, k % FL)));
    end
    // frame counter wrap across 257 frames
    do_reset();
    gen_d = 12'h340;
    run = 1;
    for (int f = 0; f < 257; f++) begin
      if (f == 256) run = 0;
      read_frame($sformatf("t4_f%0d", f), 8'(f), 8'h34, 8'h34);
    end
    // reset in the middle of channel 10 settle
    do_reset();
    gen_per = 2;
    gen_d = 12'h780;
    run = 1;
    wait_addr(6'd10, 2000, "t5_addr10");
    run = 0;
    reset = 1;
    @(negedge clk);
    reset = 0;
    check("t5_empty", 32'(tx_empty), 1);
    check("t5_addr", 32'(addr), 0);
    check("t5_busy", 32'(busy), 0);
    check("t5_data", 32'(tx_data), 0);
    run = 1;
    wait_busy(1, 10, "t5_busy_rise");
    run = 0;
    read_frame("t5", 8'h00, 8'h78, 8'h78);
    // run dropped at channel 5: frame completes, nothing after
    run = 1;
    wait_addr(6'd5, 2000, "t6_addr5");
    run = 0;
    read_frame("t6", 8'h01, 8'h78, 8'h78);
    repeat (400) @(negedge clk);
    check("t6_empty", 32'(tx_empty), 1);
    check("t6_busy", 32'(busy), 0);
    check("t6_addr_hold", 32'(addr), 23);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
